// File: rtl/spi_apb_bridge_pkg.sv
// Shared types and default parameters for the SPI-to-APB register bridge.
package spi_apb_bridge_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  localparam int          AW_DEF        = 16;
  localparam int          DW_DEF        = 16;
  localparam int          SYNC_STG_DEF  = 2;
  localparam int          TIMEOUT_DEF   = 255;
  localparam logic [15:0] ERR_RDATA_DEF = 16'hDEAD;

endpackage

// File: rtl/spi_tgl_sync.sv
// Async toggle -> SYNC_STG-flop synchroniser plus one edge-detect flop; edge pulse is 1 clk wide.
// Edge pulse is asserted SYNC_STG clk after the toggle; no backpressure, every toggle yields one pulse.
module spi_tgl_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl_in,
  output logic tgl_edge
);

  if (SYNC_STG < 2) begin : g_bad_stg
    $error("spi_tgl_sync: SYNC_STG must be at least 2");
  end

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                last_q, last_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], tgl_in};
    last_d = sync_q[SYNC_STG-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign tgl_edge = sync_q[SYNC_STG-1] ^ last_q;

endmodule

// File: rtl/spi_apb_bridge.sv
// Turns SCK-domain request toggles into single APB accesses; request-to-pending is SYNC_STG+1 clk, min access 4 clk.
// No backpressure to the SPI side: a second same-type request while one is pending is dropped and flagged in err_ovf.
module spi_apb_bridge
  import spi_apb_bridge_pkg::*;
#(
  parameter int            AW        = AW_DEF,
  parameter int            DW        = DW_DEF,
  parameter int            SYNC_STG  = SYNC_STG_DEF,
  parameter int            TIMEOUT   = TIMEOUT_DEF,
  parameter logic [DW-1:0] ERR_RDATA = DW'(ERR_RDATA_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] spi_addr,
  input  logic [DW-1:0] spi_wdata,
  input  logic          wr_req_tgl,
  input  logic          rd_req_tgl,
  input  logic          err_clr,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  input  logic          pready,
  input  logic [DW-1:0] prdata,
  input  logic          pslverr,
  output logic [DW-1:0] rdata,
  output logic          wr_ack_tgl,
  output logic          rd_ack_tgl,
  output logic          busy,
  output logic          err_slv,
  output logic          err_tmo,
  output logic          err_ovf
);

  if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_tmo
    $error("spi_apb_bridge: TIMEOUT must be in 1..256");
  end

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic wr_edge, rd_edge;

  spi_tgl_sync #(.SYNC_STG(SYNC_STG)) u_wr_sync (
    .clk(clk), .rst(rst), .tgl_in(wr_req_tgl), .tgl_edge(wr_edge)
  );
  spi_tgl_sync #(.SYNC_STG(SYNC_STG)) u_rd_sync (
    .clk(clk), .rst(rst), .tgl_in(rd_req_tgl), .tgl_edge(rd_edge)
  );

  state_e        state_q, state_d;
  logic          pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic          pwrite_q, pwrite_d, xerr_q, xerr_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic          err_slv_q, err_slv_d, err_tmo_q, err_tmo_d, err_ovf_q, err_ovf_d;
  logic          take_wr, take_rd, slv_hit, tmo_hit, ovf_hit;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    tmo_cnt_d = tmo_cnt_q;
    rbuf_d    = rbuf_q;
    xerr_d    = xerr_q;
    rdata_d   = rdata_q;
    wr_ack_d  = wr_ack_q;
    rd_ack_d  = rd_ack_q;
    take_wr   = 1'b0;
    take_rd   = 1'b0;
    slv_hit   = 1'b0;
    tmo_hit   = 1'b0;
    ovf_hit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_wr_q || pend_rd_q) begin
          take_wr   = pend_wr_q;
          take_rd   = !pend_wr_q;
          pwrite_d  = pend_wr_q;
          paddr_d   = spi_addr;
          pwdata_d  = spi_wdata;
          tmo_cnt_d = '0;
          xerr_d    = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (pready) begin
          rbuf_d  = prdata;
          slv_hit = pslverr;
          xerr_d  = pslverr;
          state_d = DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          xerr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (pwrite_q) begin
          wr_ack_d = ~wr_ack_q;
        end else begin
          rdata_d  = xerr_q ? ERR_RDATA : rbuf_q;
          rd_ack_d = ~rd_ack_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flag being taken this cycle is in service, so a fresh edge re-arms it without overflow.
    pend_wr_d = pend_wr_q & ~take_wr;
    pend_rd_d = pend_rd_q & ~take_rd;
    if (wr_edge) begin
      ovf_hit   = pend_wr_q & ~take_wr;
      pend_wr_d = 1'b1;
    end
    if (rd_edge) begin
      ovf_hit   = ovf_hit | (pend_rd_q & ~take_rd);
      pend_rd_d = 1'b1;
    end

    err_slv_d = (err_slv_q & ~err_clr) | slv_hit;
    err_tmo_d = (err_tmo_q & ~err_clr) | tmo_hit;
    err_ovf_d = (err_ovf_q & ~err_clr) | ovf_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      tmo_cnt_q <= '0;
      rbuf_q    <= '0;
      xerr_q    <= 1'b0;
      rdata_q   <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      err_slv_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      tmo_cnt_q <= tmo_cnt_d;
      rbuf_q    <= rbuf_d;
      xerr_q    <= xerr_d;
      rdata_q   <= rdata_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      err_slv_q <= err_slv_d;
      err_tmo_q <= err_tmo_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign psel       = (state_q == SETUP) || (state_q == ACCESS);
  assign penable    = (state_q == ACCESS);
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pwrite     = pwrite_q;
  assign rdata      = rdata_q;
  assign wr_ack_tgl = wr_ack_q;
  assign rd_ack_tgl = rd_ack_q;
  assign busy       = (state_q != IDLE) || pend_wr_q || pend_rd_q;
  assign err_slv    = err_slv_q;
  assign err_tmo    = err_tmo_q;
  assign err_ovf    = err_ovf_q;

endmodule
